// File: rtl/gray_ctr_checker.sv
// Read-side decoder and integrity monitor for a Gray-coded counter: synchronises,
// decodes to binary, checks each sample is a hold or +1 step, flags wraps and counts errors.
module gray_ctr_checker #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 locked,
    output logic                 step_err,
    output logic                 wrap,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } state_t;

    localparam logic [2:0] FILL_LAST = 3'(SYNC_STAGES);

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t               r_state;
    logic [2:0]           r_fill_cnt;
    logic                 r_good_cnt;
    logic [WIDTH-1:0]     r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]     r_bin_out;
    logic                 r_bin_valid;
    logic                 r_locked;
    logic                 r_step_err;
    logic                 r_wrap;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic [WIDTH-1:0]     w_dec;
    logic [WIDTH-1:0]     w_delta;
    logic                 w_checking;
    logic                 w_step_ok;
    logic                 w_step_err;
    logic                 w_wrap;

    // delta=1 with dec=0 can only come from all-ones, so wrap needs no bin_out compare.
    always_comb begin
        w_dec      = gray2bin(r_sync[SYNC_STAGES-1]);
        w_delta    = w_dec - r_bin_out;
        w_checking = (r_state == TRACK) || (r_state == ERR);
        w_step_ok  = w_checking && (w_delta == WIDTH'(1));
        w_step_err = w_checking && (w_delta != '0) && (w_delta != WIDTH'(1));
        w_wrap     = w_step_ok && (w_dec == '0);
    end

    // NOTE: every register in this block uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the sync chain is only SYNC_STAGES flops, so clearing it keeps post-reset decode defined.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_state     <= FILL;
            r_fill_cnt  <= '0;
            r_good_cnt  <= 1'b0;
            r_bin_out   <= '0;
            r_bin_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_step_err  <= 1'b0;
            r_wrap      <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_sync[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end

            r_step_err <= w_step_err;
            r_wrap     <= w_wrap;

            case (r_state)
                FILL: begin
                    if (r_fill_cnt == FILL_LAST) begin
                        r_bin_out   <= w_dec;
                        r_bin_valid <= 1'b1;
                        r_locked    <= 1'b1;
                        r_state     <= TRACK;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + 3'd1;
                    end
                end
                TRACK: begin
                    r_bin_out <= w_dec;
                    if (w_step_err) begin
                        r_state    <= ERR;
                        r_locked   <= 1'b0;
                        r_good_cnt <= 1'b0;
                    end
                end
                ERR: begin
                    r_bin_out <= w_dec;
                    if (w_step_ok) begin
                        if (r_good_cnt) begin
                            r_state    <= TRACK;
                            r_locked   <= 1'b1;
                            r_good_cnt <= 1'b0;
                        end else begin
                            r_good_cnt <= 1'b1;
                        end
                    end else if (w_step_err) begin
                        r_good_cnt <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= FILL;
                    r_locked <= 1'b0;
                end
            endcase

            // A clear coinciding with a new error keeps that error counted.
            if (clr_err) begin
                r_err_count <= w_step_err ? ERR_CNT_W'(1) : '0;
            end else if (w_step_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
        end
    end

    assign bin_out   = r_bin_out;
    assign bin_valid = r_bin_valid;
    assign locked    = r_locked;
    assign step_err  = r_step_err;
    assign wrap      = r_wrap;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_gray_ctr_checker.sv
// Bench for gray_ctr_checker: directed scenarios plus random Gray streams, every edge
// compared against a behavioural model; a second instance exercises a 2-bit error counter.
module tb_gray_ctr_checker;

    localparam int W  = 4;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] gray_in;
    logic         clr_err;

    logic [W-1:0] bin_out,   n_bin_out;
    logic         bin_valid, n_bin_valid;
    logic         locked,    n_locked;
    logic         step_err,  n_step_err;
    logic         wrap,      n_wrap;
    logic [7:0]   err_count;
    logic [1:0]   n_err_count;

    always #5 clk = ~clk;

    gray_ctr_checker #(.WIDTH(W), .SYNC_STAGES(SS), .ERR_CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .gray_in(gray_in), .clr_err(clr_err),
        .bin_out(bin_out), .bin_valid(bin_valid), .locked(locked),
        .step_err(step_err), .wrap(wrap), .err_count(err_count)
    );

    gray_ctr_checker #(.WIDTH(W), .SYNC_STAGES(SS), .ERR_CNT_W(2)) u_dut_narrow (
        .clk(clk), .reset(reset), .gray_in(gray_in), .clr_err(clr_err),
        .bin_out(n_bin_out), .bin_valid(n_bin_valid), .locked(n_locked),
        .step_err(n_step_err), .wrap(n_wrap), .err_count(n_err_count)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Behavioural model: a queue of raw samples, arithmetic decode, and a few flags.
    int m_pipe[$];
    int m_since_rst, m_bin, m_good, m_ecnt, m_ecnt_n;
    bit m_valid, m_locked, m_in_err, m_step, m_wrap;

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < W; s++) b ^= (g >> s);
        return b & ((1 << W) - 1);
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & ((1 << W) - 1);
    endfunction

    task automatic model_edge(input bit rst, input int g, input bit clr);
        int dec, d;
        if (rst) begin
            m_pipe = {};
            for (int i = 0; i < SS; i++) m_pipe.push_front(0);
            m_since_rst = 0; m_bin = 0; m_good = 0; m_ecnt = 0; m_ecnt_n = 0;
            m_valid = 0; m_locked = 0; m_in_err = 0; m_step = 0; m_wrap = 0;
            return;
        end
        dec = g2b(m_pipe[$]);
        void'(m_pipe.pop_back());
        m_pipe.push_front(g);
        m_step = 0;
        m_wrap = 0;
        if (!m_valid) begin
            if (m_since_rst == SS) begin
                m_bin = dec; m_valid = 1; m_locked = 1;
            end else begin
                m_since_rst++;
            end
        end else begin
            d = (dec - m_bin) & ((1 << W) - 1);
            if (d == 1) begin
                m_wrap = (dec == 0);
                if (m_in_err) begin
                    m_good++;
                    if (m_good == 2) begin
                        m_in_err = 0; m_locked = 1; m_good = 0;
                    end
                end
            end else if (d != 0) begin
                m_step = 1; m_in_err = 1; m_locked = 0; m_good = 0;
            end
            m_bin = dec;
        end
        if (clr) begin
            m_ecnt   = m_step;
            m_ecnt_n = m_step;
        end else if (m_step) begin
            if (m_ecnt < 255) m_ecnt++;
            if (m_ecnt_n < 3) m_ecnt_n++;
        end
    endtask

    task automatic drive(input bit rst, input int g, input bit clr);
        reset   = rst;
        gray_in = W'(g);
        clr_err = clr;
        @(posedge clk);
        model_edge(rst, g, clr);
        #1;
        check("bin_out",   32'(bin_out),   32'(m_bin));
        check("bin_valid", 32'(bin_valid), 32'(m_valid));
        check("locked",    32'(locked),    32'(m_locked));
        check("step_err",  32'(step_err),  32'(m_step));
        check("wrap",      32'(wrap),      32'(m_wrap));
        check("err_count", 32'(err_count), 32'(m_ecnt));
        check("n_err_count", 32'(n_err_count), 32'(m_ecnt_n));
        check("n_locked",  32'(n_locked),  32'(m_locked));
    endtask

    task automatic send(input int b, input bit clr = 1'b0);
        drive(1'b0, b2g(b), clr);
    endtask

    initial begin
        int cnt;
        int r;
        reset = 1'b1; gray_in = '0; clr_err = 1'b0;

        // Reset state, then 0,1,2,3,4; acquire on the third edge after release.
        drive(1'b1, 0, 1'b0);
        drive(1'b1, 0, 1'b0);
        for (int b = 0; b <= 4; b++) send(b);
        check("t1_valid", 32'(bin_valid), 32'd1);
        check("t1_bin_2", 32'(bin_out), 32'd2);

        // Hold at 4 for six cycles.
        for (int i = 0; i < 6; i++) send(4);
        check("t3_bin_hold", 32'(bin_out), 32'd4);

        // Count through 15 -> 0 to see the wrap pulse.
        for (int b = 5; b <= 17; b++) send(b & 15);
        send(2); send(2);

        // Illegal jump 2 -> 6, then 7, 8 to relock.
        send(6); send(7); send(8); send(8); send(8);
        check("t4_relock", 32'(locked), 32'd1);
        check("t4_ecnt", 32'(err_count), 32'd1);

        // Five more illegal jumps saturate the 2-bit counter at 3.
        send(0); send(8); send(0); send(8); send(0); send(0); send(0);
        check("t5_sat", 32'(n_err_count), 32'd3);
        // Sixth error decodes two edges after its input; clear lands on that edge.
        send(8); send(8); send(8, 1'b1);
        check("t5_clr_err", 32'(n_err_count), 32'd1);
        check("t5_step", 32'(step_err), 32'd1);

        // Relock, then a one-cycle reset mid-track.
        send(9); send(10); send(11); send(11); send(11);
        drive(1'b1, b2g(11), 1'b0);
        check("t6_rst_locked", 32'(locked), 32'd0);
        check("t6_rst_bin", 32'(bin_out), 32'd0);
        for (int i = 0; i < 5; i++) send(11);
        check("t6_reacq_bin", 32'(bin_out), 32'd11);
        check("t6_reacq_err", 32'(err_count), 32'd0);

        // Random Gray stream: mostly steps and holds, some jumps, clears and resets.
        cnt = 11;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(99);
            if (r < 55)      cnt = (cnt + 1) & 15;
            else if (r < 85) cnt = cnt;
            else             cnt = $urandom_range(15);
            if ($urandom_range(63) == 0)
                drive(1'b1, b2g(cnt), 1'b0);
            else
                drive(1'b0, b2g(cnt), ($urandom_range(39) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
